// File: rtl/run_detect_scheduler.sv
// run_detect_scheduler
//   Shares one run-length detector (four or more equal bits in a row) across
//   N serial bit channels. Each channel keeps its 4-bit detector state in a
//   context register; a round-robin arbiter picks at most one requesting
//   channel per cycle, and that channel's bit is stepped through the shared
//   next-state logic and written back.
//
// Ports
//   clk        rising-edge clock
//   aclr       asynchronous reset, active-low
//   req[N]     channel i has a bit ready on w[i] (held until gnt[i])
//   w[N]       serial data bit per channel
//   clr[N]     synchronous per-channel context clear, beats req
//   gnt[N]     one-hot grant, combinational; bit consumed this cycle
//   z[N]       per-channel detect flag (context is E or I), registered
//   last_ch    index of the most recently granted channel
//   last_y     context state written for last_ch
//   det_pulse  one-cycle pulse after any channel's z rose
//   det_cnt    saturating count of z rising events
//
// Context codes: A=0 idle, B..E=1..4 one to four+ zeros, F..I=5..8 one to
// four+ ones, 9..15 are illegal and fall back to A.
module run_detect_scheduler #(
   parameter int N    = 4,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            aclr,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    w,
   input  logic [N-1:0]    clr,
   output logic [N-1:0]    gnt,
   output logic [N-1:0]    z,
   output logic [2:0]      last_ch,
   output logic [3:0]      last_y,
   output logic            det_pulse,
   output logic [CNTW-1:0] det_cnt
);

   localparam logic [3:0]      NL      = 4'(N);
   localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

   typedef enum logic [3:0] {
      S_A = 4'd0, S_B = 4'd1, S_C = 4'd2, S_D = 4'd3, S_E = 4'd4,
      S_F = 4'd5, S_G = 4'd6, S_H = 4'd7, S_I = 4'd8
   } ctx_t;

   function automatic logic [3:0] next_state(input logic [3:0] s, input logic b);
      logic [3:0] n;
      n = S_A;
      case (s)
         S_A, S_B, S_C, S_D: n = b ? S_F : s + 4'd1;
         S_E:                n = b ? S_F : S_E;
         S_F, S_G, S_H:      n = b ? s + 4'd1 : S_B;
         S_I:                n = b ? S_I : S_B;
         default:            n = S_A;
      endcase
      return n;
   endfunction

   function automatic logic is_detect(input logic [3:0] s);
      return (s == S_E) || (s == S_I);
   endfunction

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   logic [3:0] ctx [N];
   logic [2:0] ptr;

   logic [N-1:0] elig;
   logic [3:0]   scan;
   logic         vld_p0;
   logic [2:0]   idx_p0;
   logic [3:0]   ctx_sel_p0;
   logic         w_sel_p0;
   logic         z_sel_p0;
   logic [3:0]   ctx_new_p0;
   logic         z_new_p0;
   logic [3:0]   ptr_inc;

   // Stage p0: round-robin pick, context fetch and shared next-state logic
   assign elig = req & ~clr;

   always_comb begin
      vld_p0 = 1'b0;
      idx_p0 = 3'd0;
      scan   = 4'd0;
      for (int k = 0; k < N; k++) begin
         scan = {1'b0, ptr} + 4'(k);
         if (scan >= NL) scan = scan - NL;
         if (!vld_p0 && elig[scan[2:0]]) begin
            vld_p0 = 1'b1;
            idx_p0 = scan[2:0];
         end
      end
   end

   // Grant is forced low while reset is held so no requester sees a consume.
   always_comb begin
      gnt = '0;
      for (int i = 0; i < N; i++)
         if (aclr && vld_p0 && idx_p0 == 3'(i)) gnt[i] = 1'b1;
   end

   always_comb begin
      ctx_sel_p0 = S_A;
      w_sel_p0   = 1'b0;
      z_sel_p0   = 1'b0;
      for (int i = 0; i < N; i++)
         if (idx_p0 == 3'(i)) begin
            ctx_sel_p0 = ctx[i];
            w_sel_p0   = w[i];
            z_sel_p0   = z[i];
         end
   end

   assign ctx_new_p0 = next_state(ctx_sel_p0, w_sel_p0);
   assign z_new_p0   = is_detect(ctx_new_p0);
   assign ptr_inc    = {1'b0, idx_p0} + 4'd1;

   // Stage p1: context write-back, status registers and event counter
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         for (int i = 0; i < N; i++) ctx[i] <= S_A;
         z         <= '0;
         ptr       <= 3'd0;
         last_ch   <= 3'd0;
         last_y    <= 4'd0;
         det_pulse <= 1'b0;
         det_cnt   <= '0;
      end else begin
         det_pulse <= 1'b0;
         for (int i = 0; i < N; i++) begin
            if (clr[i]) begin
               ctx[i] <= S_A;
               z[i]   <= 1'b0;
            end else if (vld_p0 && idx_p0 == 3'(i)) begin
               ctx[i] <= ctx_new_p0;
               z[i]   <= z_new_p0;
            end
         end
         if (vld_p0) begin
            ptr     <= (ptr_inc == NL) ? 3'd0 : ptr_inc[2:0];
            last_ch <= idx_p0;
            last_y  <= ctx_new_p0;
            // Only a 0->1 edge of the granted channel's flag is an event;
            // sitting in E or I keeps z high without re-triggering.
            if (z_new_p0 && !z_sel_p0) begin
               det_pulse <= 1'b1;
               det_cnt   <= sat_inc(det_cnt);
            end
         end
      end
   end

endmodule

// File: tb/tb_run_detect_scheduler.sv
module tb_run_detect_scheduler;

   localparam int N = 4;

   logic         clk;
   logic         aclr;
   logic [N-1:0] req, w, clr;
   logic [N-1:0] gnt, z, gnt2, z2;
   logic [2:0]   last_ch, last_ch2;
   logic [3:0]   last_y, last_y2;
   logic         det_pulse, det_pulse2;
   logic [7:0]   det_cnt;
   logic [1:0]   det_cnt2;

   run_detect_scheduler #(.N(N), .CNTW(8)) dut (
      .clk(clk), .aclr(aclr), .req(req), .w(w), .clr(clr),
      .gnt(gnt), .z(z), .last_ch(last_ch), .last_y(last_y),
      .det_pulse(det_pulse), .det_cnt(det_cnt)
   );

   run_detect_scheduler #(.N(N), .CNTW(2)) dut2 (
      .clk(clk), .aclr(aclr), .req(req), .w(w), .clr(clr),
      .gnt(gnt2), .z(z2), .last_ch(last_ch2), .last_y(last_y2),
      .det_pulse(det_pulse2), .det_cnt(det_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: each channel is a run length plus the bit value of
   // the run; the detector code is derived from those.
   int run [N];
   int pol [N];
   bit zm  [N];
   int mptr, mlast_ch, mlast_y, mcnt, mcnt2;
   bit mpulse;
   int lastg;

   function automatic int code_of(input int r, input int p);
      int len;
      if (r == 0) return 0;
      len = (r > 4) ? 4 : r;
      return (p != 0) ? 4 + len : len;
   endfunction

   function automatic int pick(input logic [N-1:0] r, input logic [N-1:0] c);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (mptr + k) % N;
         if (r[j] && !c[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         run[i] = 0; pol[i] = 0; zm[i] = 0;
      end
      mptr = 0; mlast_ch = 0; mlast_y = 0; mcnt = 0; mcnt2 = 0; mpulse = 0;
   endtask

   function automatic logic [N-1:0] zvec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = zm[i];
      return v;
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".z"},        32'(z),         32'(zvec()));
      chk({tag, ".last_ch"},  32'(last_ch),   32'(mlast_ch));
      chk({tag, ".last_y"},   32'(last_y),    32'(mlast_y));
      chk({tag, ".pulse"},    32'(det_pulse), 32'(mpulse));
      chk({tag, ".cnt"},      32'(det_cnt),   32'(mcnt));
      chk({tag, ".cnt2"},     32'(det_cnt2),  32'(mcnt2));
   endtask

   // Called at posedge+1: drive, check the combinational grant, advance the
   // model across the edge, then check the registered outputs.
   task automatic step(input logic [N-1:0] r, input logic [N-1:0] wv, input logic [N-1:0] c);
      int g;
      int ny;
      req = r; w = wv; clr = c;
      #1;
      g = pick(r, c);
      chk("gnt", 32'(gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
      mpulse = 0;
      for (int i = 0; i < N; i++)
         if (c[i]) begin run[i] = 0; zm[i] = 0; end
      if (g >= 0) begin
         if (run[g] == 0 || pol[g] != int'(wv[g])) begin
            pol[g] = int'(wv[g]);
            run[g] = 1;
         end else if (run[g] < 4) begin
            run[g] = run[g] + 1;
         end
         ny = code_of(run[g], pol[g]);
         if (run[g] >= 4 && !zm[g]) begin
            mpulse = 1;
            if (mcnt < 255) mcnt++;
            if (mcnt2 < 3) mcnt2++;
         end
         zm[g] = (run[g] >= 4);
         mptr = (g + 1) % N;
         mlast_ch = g;
         mlast_y = ny;
      end
      lastg = g;
      @(posedge clk); #1;
      check_outputs("step");
   endtask

   logic [N-1:0] pend, pw, rc;

   initial begin
      req = '0; w = '0; clr = '0;
      aclr = 1'b0;
      model_reset();
      lastg = -1;
      repeat (2) @(posedge clk);
      #1;
      req = 4'b1111;
      #1;
      chk("rst.gnt", 32'(gnt), 32'd0);
      check_outputs("rst");
      req = '0;
      aclr = 1'b1;

      // ch0 alone, four zeros: B,C,D,E then one pulse
      repeat (4) step(4'b0001, 4'b0000, 4'b0000);
      // three more zeros stay in E, then a one and three more ones reach I
      repeat (3) step(4'b0001, 4'b0000, 4'b0000);
      repeat (4) step(4'b0001, 4'b0001, 4'b0000);

      // all channels requesting
      for (int k = 0; k < 8; k++) step(4'b1111, 4'($urandom_range(0, 15)), 4'b0000);

      // ch1 ones, ch2 zeros, interleaved
      for (int k = 0; k < 8; k++) step(4'b0110, 4'b0010, 4'b0000);

      // ch3 to H, park ptr on 3, then clear ch3 while it requests
      repeat (3) step(4'b1000, 4'b1000, 4'b0000);
      step(4'b0100, 4'b0000, 4'b0000);
      step(4'b1001, 4'b1001, 4'b1000);

      // randomized traffic honouring the hold-until-grant handshake
      pend = '0; pw = '0;
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
               pend[i] = ($urandom_range(0, 3) != 0);
               pw[i]   = ($urandom_range(0, 4) == 0) ? 1'($urandom_range(0, 1)) : pw[i];
            end
            rc[i] = ($urandom_range(0, 15) == 0);
         end
         step(pend, pw, rc);
         if (lastg >= 0) pend[lastg] = 1'b0;

         if (k == 300) begin
            // asynchronous reset mid-cycle with traffic pending
            req = 4'b1111;
            #2;
            aclr = 1'b0;
            #1;
            model_reset();
            chk("aclr.gnt", 32'(gnt), 32'd0);
            check_outputs("aclr");
            @(posedge clk); #1;
            chk("aclr.hold.gnt", 32'(gnt), 32'd0);
            check_outputs("aclr.hold");
            aclr = 1'b1;
            pend = '0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/run_detect_scheduler.md
# run_detect_scheduler

Time-multiplexes one shared run-length detector across N serial bit channels. The detector flags four or more consecutive 0s or four or more consecutive 1s. Each channel's 4-bit detector state lives in a context register. A round-robin arbiter grants at most one requesting channel per cycle. The granted channel's bit is pushed through the shared next-state logic, and the result is written back to that channel's context. The block sits between the serial front-ends and the status/interrupt logic.

## Interface
- N, default 4: number of channels, 2..8.
- CNTW, default 8: width of the detection event counter.

- clk  input  1  clock, rising edge.
- aclr  input  1  asynchronous reset, active-low.
- req  input  N  channel i has a bit ready on w[i]; held until gnt[i].
- w  input  N  serial data bit per channel; stable while req[i]=1.
- clr  input  N  synchronous per-channel context clear.
- gnt  output  N  one-hot grant, combinational; bit consumed this cycle.
- z  output  N  per-channel detect flag, registered.
- last_ch  output  3  index of the most recently granted channel, registered.
- last_y  output  4  new context state written for last_ch, registered.
- det_pulse  output  1  one-cycle pulse: a channel's z rose on the previous edge.
- det_cnt  output  CNTW  count of z rising events, saturating at all-ones.

## Operation
- Context encoding:
  - A=0: idle.
  - B=1, C=2, D=3, E=4: one to four or more consecutive 0s.
  - F=5, G=6, H=7, I=8: one to four or more consecutive 1s.
- Next state for input bit w:
  - On w=0: A/B/C/D step to B/C/D/E; E stays E; F/G/H/I go to B.
  - On w=1: A/B/C/D/E go to F; F/G/H step to G/H/I; I stays I.
  - Codes 9..15 go to A for either w value.
- z for a channel is 1 exactly when its context is E or I.
- Arbitration:
  - Eligible channels: req[i]=1 and clr[i]=0.
  - Scan eligible channels from pointer ptr upward, modulo N; the first hit is granted.
  - After a grant, ptr = granted index + 1 (mod N).
  - With no grant, ptr holds.
- clr[i] priority: clr[i] wins over req[i]. Context i goes to A, z[i] goes to 0, and no grant is given to i that cycle.
- On a grant to channel g:
  - ctx[g] ← next(ctx[g], w[g]).
  - z[g] ← (new state is E or I).
  - last_ch ← g; last_y ← new state.
- Ungranted, uncleared contexts hold their value.
- det_pulse asserts when z[g] goes 0→1 because of a grant.
  - Staying in E or I produces no pulse.
  - det_cnt increments on each det_pulse and saturates at 2^CNTW−1.

## Timing
- Reset (aclr=0) sets all of the following; state is held while aclr is low:
  - every context to A, z=0, ptr=0;
  - last_ch=0, last_y=0;
  - det_pulse=0, det_cnt=0.
- gnt is combinational from req, clr and ptr in the same cycle. gnt is all zeros during reset.
- Grant to channel g in cycle k:
  - context, z[g], last_ch and last_y update at the edge ending cycle k;
  - det_pulse is high during cycle k+1;
  - det_cnt shows the increment from cycle k+1.
- Requester handshake: sample gnt[i] at the rising edge. If it is 1, the bit was consumed; present the next bit or drop req.
- Throughput: one bit per cycle in aggregate. With all N channels requesting, each channel is granted once every N cycles.
- aclr asserted mid-stream discards all contexts and any in-flight grant. The bit offered in that cycle is lost.

## Test plan
- After reset, ch0 alone with w=0 for 4 grants: gnt=0001 each cycle; last_y=1,2,3,4; z[0]=1 after the 4th edge; det_pulse for one cycle; det_cnt=1.
- req=1111 held for 8 cycles: gnt sequence 0001,0010,0100,1000,0001,… and each channel advances exactly one state per grant.
- Interleaved streams, ch1 all 1s and ch2 all 0s, both requesting: contexts stay independent; after 4 grants each, ch1=I, ch2=E, z=0110, det_cnt=2.
- Saturation and flip: ch0 in E gets 3 more 0s, so z[0] stays 1 and det_cnt is unchanged. Then w=1 gives state F, z[0]=0. Three more 1s give I, z[0]=1, and det_cnt increments.
- clr[3] and req[3] in the same cycle with ch3 at H: gnt[3]=0, ctx3=A, z[3]=0, and the grant passes to the next eligible channel. aclr pulsed mid-run makes every output 0 immediately.
- With CNTW=2, drive 5 detection events: det_cnt reads 1,2,3,3,3.
